// File: rtl/grid_io_shadow_cfg_tile.sv
// IO grid tile: N_IO embedded-IO subtiles configured through one scan chain,
// with an optional shadow bank so pad direction only changes on a commit.
module grid_io_shadow_cfg_tile #(
  parameter int N_IO   = 8,
  parameter int SHADOW = 1
) (
  input  logic            prog_clk,
  input  logic            pReset_n,
  input  logic            IO_ISOL_N,
  input  logic            ccff_head,
  input  logic            ccff_en,
  input  logic            ccff_load,
  input  logic [N_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
  output logic [N_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
  output logic [N_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
  input  logic [N_IO-1:0] io_outpad,
  output logic [N_IO-1:0] io_inpad,
  output logic            ccff_tail,
  output logic            cfg_loaded,
  output logic            cfg_count_ok
);

  localparam int L  = 2 * N_IO;
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(L);
  // Counter parks one past L so an over-length shift never reads as exact.
  localparam logic [CW-1:0] CNT_SAT  = CW'(L + 1);

  logic [L-1:0]    sr;
  logic [L-1:0]    act;
  logic [CW-1:0]   cnt;
  logic [N_IO-1:0] oe;
  logic [N_IO-1:0] inv;
  logic [N_IO-1:0] drive_en;
  logic [N_IO-1:0] isol_mask;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      sr           <= '0;
      cnt          <= '0;
      cfg_loaded   <= 1'b0;
      cfg_count_ok <= 1'b0;
    end else begin
      if (ccff_en) begin
        sr <= {sr[L-2:0], ccff_head};
      end
      if (ccff_load) begin
        cfg_loaded   <= 1'b1;
        cfg_count_ok <= (cnt == CNT_FULL);
        cnt          <= ccff_en ? CW'(1) : '0;
      end else if (ccff_en && (cnt != CNT_SAT)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  generate
    if (SHADOW != 0) begin : g_shadow
      logic [L-1:0] shadow;

      // Captures the pre-edge chain, so a shift on the commit edge is not seen.
      always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
          shadow <= '0;
        end else if (ccff_load) begin
          shadow <= sr;
        end
      end

      assign act = shadow;
    end else begin : g_direct
      assign act = sr;
    end
  endgenerate

  assign ccff_tail = sr[L-1];

  always_comb begin
    oe  = '0;
    inv = '0;
    for (int i = 0; i < N_IO; i++) begin
      oe[i]  = act[2*i];
      inv[i] = act[2*i+1];
    end
  end

  assign isol_mask = {N_IO{IO_ISOL_N}};
  assign drive_en  = isol_mask & oe;

  assign gfpga_pad_EMBEDDED_IO_HD_SOC_OUT = drive_en & (io_outpad ^ inv);
  assign gfpga_pad_EMBEDDED_IO_HD_SOC_DIR = ~drive_en;
  assign io_inpad = isol_mask & ~oe & (gfpga_pad_EMBEDDED_IO_HD_SOC_IN ^ inv);

endmodule

// File: tb/tb_grid_io_shadow_cfg_tile.sv
// Scoreboard bench: stimulus queues expected pad/status values, a negedge
// monitor pops and compares them against three tile instances.
module tb_grid_io_shadow_cfg_tile;

  logic       clk = 1'b0;
  logic       rst_n, isol, head, en, load;
  logic [7:0] soc_in, outpad;
  logic [7:0] out0, dir0, inpad0, out1, dir1, inpad1;
  logic       tail0, loaded0, ok0, tail1, loaded1, ok1;
  logic       head2, en2, load2, soc_in2, outpad2;
  logic       out2, dir2, inpad2, tail2, loaded2, ok2;

  always #5 clk = ~clk;

  grid_io_shadow_cfg_tile #(.N_IO(8), .SHADOW(1)) u0 (
    .prog_clk(clk), .pReset_n(rst_n), .IO_ISOL_N(isol), .ccff_head(head),
    .ccff_en(en), .ccff_load(load),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_IN(soc_in), .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT(out0),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR(dir0), .io_outpad(outpad), .io_inpad(inpad0),
    .ccff_tail(tail0), .cfg_loaded(loaded0), .cfg_count_ok(ok0));

  grid_io_shadow_cfg_tile #(.N_IO(8), .SHADOW(0)) u1 (
    .prog_clk(clk), .pReset_n(rst_n), .IO_ISOL_N(isol), .ccff_head(head),
    .ccff_en(en), .ccff_load(load),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_IN(soc_in), .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT(out1),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR(dir1), .io_outpad(outpad), .io_inpad(inpad1),
    .ccff_tail(tail1), .cfg_loaded(loaded1), .cfg_count_ok(ok1));

  grid_io_shadow_cfg_tile #(.N_IO(1), .SHADOW(1)) u2 (
    .prog_clk(clk), .pReset_n(rst_n), .IO_ISOL_N(isol), .ccff_head(head2),
    .ccff_en(en2), .ccff_load(load2),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_IN(soc_in2), .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT(out2),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR(dir2), .io_outpad(outpad2), .io_inpad(inpad2),
    .ccff_tail(tail2), .cfg_loaded(loaded2), .cfg_count_ok(ok2));

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  logic [15:0] sr_m, sh_m;

  function automatic logic [7:0] actual(input int sel);
    case (sel)
      0:  return dir0;
      1:  return out0;
      2:  return inpad0;
      3:  return {7'd0, tail0};
      4:  return {7'd0, loaded0};
      5:  return {7'd0, ok0};
      6:  return dir1;
      7:  return out1;
      8:  return inpad1;
      9:  return {7'd0, tail1};
      10: return {7'd0, dir2};
      11: return {7'd0, out2};
      12: return {7'd0, inpad2};
      13: return {7'd0, ok2};
      14: return {7'd0, loaded2};
      default: return 8'hxx;
    endcase
  endfunction

  exp_t       cur;
  logic [7:0] act_v;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      cur   = q.pop_front();
      act_v = actual(cur.sel);
      total++;
      if (act_v !== cur.v) begin
        bad++;
        $display("FAIL %s: got %h want %h", cur.name, act_v, cur.v);
      end
    end
  end

  task automatic expect_v(input string nm, input int sel, input logic [7:0] v);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.v    = v;
    q.push_back(e);
  endtask

  // Pad behaviour of an 8-subtile tile given the active config word.
  function automatic logic [23:0] pad_model(input logic [15:0] c, input logic iso,
                                            input logic [7:0] op, input logic [7:0] si);
    logic [7:0] oe, inv, e;
    for (int i = 0; i < 8; i++) begin
      oe[i]  = c[2*i];
      inv[i] = c[2*i+1];
    end
    e = {8{iso}} & oe;
    return {~e, e & (op ^ inv), {8{iso}} & ~oe & (si ^ inv)};
  endfunction

  task automatic pad_exp(input string nm, input int base, input logic [15:0] c);
    logic [23:0] m;
    m = pad_model(c, isol, outpad, soc_in);
    expect_v({nm, "_dir"}, base, m[23:16]);
    expect_v({nm, "_out"}, base + 1, m[15:8]);
    expect_v({nm, "_inpad"}, base + 2, m[7:0]);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    head = b;
    en   = 1'b1;
    load = 1'b0;
    sync();
    sr_m = {sr_m[14:0], b};
    en   = 1'b0;
  endtask

  task automatic load_pulse();
    en   = 1'b0;
    load = 1'b1;
    sync();
    sh_m = sr_m;
    load = 1'b0;
  endtask

  task automatic shift_load(input logic b);
    head = b;
    en   = 1'b1;
    load = 1'b1;
    sync();
    sh_m = sr_m;
    sr_m = {sr_m[14:0], b};
    en   = 1'b0;
    load = 1'b0;
  endtask

  task automatic shift2(input logic b);
    head2 = b;
    en2   = 1'b1;
    sync();
    en2   = 1'b0;
  endtask

  task automatic load2_pulse();
    load2 = 1'b1;
    sync();
    load2 = 1'b0;
  endtask

  localparam logic [15:0] CFG_A = 16'h0009;
  localparam logic [15:0] CFG_B = 16'hD575;
  localparam logic [15:0] CFG_C = 16'h0003;
  localparam logic [15:0] CFG_D = 16'h0041;

  initial begin
    rst_n = 1'b0; isol = 1'b1; head = 1'b0; en = 1'b0; load = 1'b0;
    soc_in = 8'h3C; outpad = 8'hA5;
    head2 = 1'b0; en2 = 1'b0; load2 = 1'b0; soc_in2 = 1'b1; outpad2 = 1'b1;
    sr_m = '0; sh_m = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Random traffic including a commit, then reset in the middle of a cycle.
    for (int k = 0; k < 5; k++) shift_bit(1'($urandom_range(0, 1)));
    load_pulse();
    for (int k = 0; k < 3; k++) shift_bit(1'($urandom_range(0, 1)));
    head = 1'b1; en = 1'b1;
    #2 rst_n = 1'b0;
    en = 1'b0; sr_m = '0; sh_m = '0;
    expect_v("rst_dir0", 0, 8'hFF);
    expect_v("rst_out0", 1, 8'h00);
    expect_v("rst_inpad0", 2, 8'h3C);
    expect_v("rst_tail0", 3, 8'h00);
    expect_v("rst_loaded0", 4, 8'h00);
    expect_v("rst_ok0", 5, 8'h00);
    expect_v("rst_dir1", 6, 8'hFF);
    expect_v("rst_inpad1", 8, 8'h3C);
    expect_v("rst_dir2", 10, 8'h01);
    expect_v("rst_out2", 11, 8'h00);
    expect_v("rst_inpad2", 12, 8'h01);
    expect_v("rst_ok2", 13, 8'h00);
    sync();
    rst_n = 1'b1;
    sync();

    // Full program: subtile0 OE=1/INV=0, subtile1 OE=0/INV=1.
    for (int j = 15; j >= 0; j--) shift_bit(CFG_A[j]);
    expect_v("pre_load_dir0", 0, 8'hFF);
    expect_v("pre_load_ok0", 5, 8'h00);
    expect_v("direct_dir1", 6, 8'hFE);
    load_pulse();
    expect_v("full_ok0", 5, 8'h01);
    expect_v("full_loaded0", 4, 8'h01);
    expect_v("full_dir0", 0, 8'hFE);
    expect_v("full_out0", 1, 8'h01);
    expect_v("full_inpad0", 2, 8'h3E);
    expect_v("full_inpad1", 8, 8'h3E);
    sync();
    outpad = 8'hA4;
    expect_v("full_out0_follow", 1, 8'h00);
    sync();
    outpad = 8'h0F;

    // New config shifted without commit: shadowed pads hold, direct pads track.
    for (int j = 15; j >= 0; j--) begin
      shift_bit(CFG_B[j]);
      expect_v("hold_dir0", 0, 8'hFE);
      expect_v("hold_out0", 1, 8'h01);
      expect_v("hold_tail0", 3, {7'd0, sr_m[15]});
      expect_v("track_tail1", 9, {7'd0, sr_m[15]});
      pad_exp("track_u1", 6, sr_m);
    end
    expect_v("first_bit_tail0", 3, 8'h01);
    load_pulse();
    expect_v("b_ok0", 5, 8'h01);
    expect_v("b_dir0", 0, 8'h00);
    expect_v("b_out0", 1, 8'h8B);
    expect_v("b_inpad0", 2, 8'h00);
    sync();

    isol = 1'b0;
    expect_v("iso_dir0", 0, 8'hFF);
    expect_v("iso_out0", 1, 8'h00);
    expect_v("iso_inpad0", 2, 8'h00);
    expect_v("iso_dir1", 6, 8'hFF);
    expect_v("iso_out1", 7, 8'h00);
    expect_v("iso_inpad1", 8, 8'h00);
    sync();
    isol = 1'b1;
    expect_v("unisol_dir0", 0, 8'h00);
    expect_v("unisol_out0", 1, 8'h8B);
    sync();

    // Short and long shift counts still commit but flag the error.
    for (int j = 14; j >= 0; j--) shift_bit(CFG_C[j]);
    load_pulse();
    expect_v("short_ok0", 5, 8'h00);
    expect_v("short_loaded0", 4, 8'h01);
    expect_v("short_dir0", 0, 8'hFE);
    expect_v("short_out0", 1, 8'h00);
    pad_exp("short_u0", 0, sh_m);
    sync();
    for (int k = 0; k < 20; k++) shift_bit((k % 3) == 0);
    load_pulse();
    expect_v("long_ok0", 5, 8'h00);
    pad_exp("long_u0", 0, sh_m);
    sync();

    // Shift and commit on the same edge.
    for (int j = 15; j >= 0; j--) shift_bit(CFG_D[j]);
    shift_load(1'b1);
    expect_v("sim_ok0", 5, 8'h01);
    expect_v("sim_dir0", 0, 8'hF6);
    pad_exp("sim_u0", 0, sh_m);
    sync();
    for (int k = 0; k < 16; k++) shift_bit(1'b0);
    load_pulse();
    expect_v("after_sim_ok0", 5, 8'h00);
    expect_v("after_sim_dir0", 0, 8'hFF);
    sync();

    // Single-subtile tile: OE=1, INV=0.
    shift2(1'b0);
    shift2(1'b1);
    load2_pulse();
    expect_v("n1_ok2", 13, 8'h01);
    expect_v("n1_loaded2", 14, 8'h01);
    expect_v("n1_dir2", 10, 8'h00);
    expect_v("n1_out2", 11, 8'h01);
    expect_v("n1_inpad2", 12, 8'h00);
    sync();
    outpad2 = 1'b0;
    expect_v("n1_out2_follow", 11, 8'h00);
    sync();
    shift2(1'b1);
    shift2(1'b0);
    shift2(1'b0);
    load2_pulse();
    expect_v("n1_long_ok2", 13, 8'h00);
    expect_v("n1_long_dir2", 10, 8'h01);
    sync();

    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
